// File: rtl/ar0134_rx_timing.sv
// -----------------------------------------------------------------------------
// ar0134_rx_timing
// Receives the AR0134 parallel sensor stream (FV/LV/data) on the sensor pixel
// clock and re-times it for an HDMI transmitter stage: data enable, active-high
// H/V syncs and 2-cycle-latency pixel data. It also measures every frame
// (pixels of the last line, lines per frame), counts completed frames and,
// optionally, flags frames that do not match the expected geometry.
//
// Optional feature macro: AR0134_RX_CHECK_EN
//   defined   -> line-length mismatch tracking and EXP_PIX/EXP_LINE comparison
//                drive oFrameErr
//   undefined -> oFrameErr is constant 0; all other outputs are unchanged
//
// Ports
//   iPixelClk      sensor pixel clock (only clock, rising edge)
//   iRstn          asynchronous active-low reset
//   iFV, iLV       sensor frame / line valid
//   iData[11:2]    sensor pixel data
//   oDE            data enable (stage-2 LV & stage-2 FV & ACTIVE)
//   oHS            horizontal sync, HS_WIDTH cycles after each line
//   oVS            vertical sync (stage-2 FV, low while resynchronising)
//   oData[9:0]     pixel data aligned with oDE, held while oDE is low
//   oPixPerLine    pixels of the last line of the last frame
//   oLinePerFrame  lines of the last frame
//   oMeasValid     one-cycle pulse when the measurement outputs update
//   oFrameErr      error status of the last frame
//   oFrameCnt      completed frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module ar0134_rx_timing #(
  parameter int EXP_PIX  = 1282,
  parameter int EXP_LINE = 722,
  parameter int HS_WIDTH = 40
) (
  input  logic        iPixelClk,
  input  logic        iRstn,
  input  logic        iFV,
  input  logic        iLV,
  input  logic [11:2] iData,
  output logic        oDE,
  output logic        oHS,
  output logic        oVS,
  output logic [9:0]  oData,
  output logic [11:0] oPixPerLine,
  output logic [11:0] oLinePerFrame,
  output logic        oMeasValid,
  output logic        oFrameErr,
  output logic [7:0]  oFrameCnt
);

  localparam int HCW = (HS_WIDTH < 1) ? 1 : $clog2(HS_WIDTH + 1);
  localparam logic [HCW-1:0] HS_LOAD = HCW'(HS_WIDTH);
  localparam logic [11:0]    CNT_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    WAIT_FV = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  // Stage 1 holds FV/LV/data. Stage 2 of LV and data is folded into the
  // registered oDE/oData (loaded from stage 1 with the next state), so only
  // FV keeps an explicit stage-2 flop for edge detection.
  logic            fv1_q, lv1_q, fv2_q, pipe_vld_q;
  logic [9:0]      data1_q;
  logic            de_q, de_d, vs_q, vs_d, hs_q, hs_d, de_end_q;
  logic [9:0]      data_q, data_d;
  logic [HCW-1:0]  hs_cnt_q, hs_cnt_d;
  logic [11:0]     pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [11:0]     last_len_q, last_len_d;
  logic [11:0]     pix_out_q, pix_out_d, line_out_q, line_out_d;
  logic            mv_q, mv_d, err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            fv_rise, fv_fall, line_start, line_end, frame_err;

  assign fv_rise = fv1_q & ~fv2_q;
  assign fv_fall = ~fv1_q & fv2_q;

  // Next-state logic of the frame tracker.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // pipe_vld_q ensures the low FV seen here is a real sample, not the
      // reset value, so a frame in progress at reset release is discarded.
      SYNC:    if (pipe_vld_q && !fv1_q) state_d = WAIT_FV; else state_d = state_q;
      WAIT_FV: if (fv_rise) state_d = ACTIVE; else state_d = state_q;
      ACTIVE:  if (fv_fall) state_d = DONE;   else state_d = state_q;
      DONE:    state_d = WAIT_FV;
      default: state_d = SYNC;
    endcase
  end

  // Output timing, per-line/per-frame counters and DONE-time measurement load.
  always_comb begin
    de_d       = lv1_q & fv1_q & (state_d == ACTIVE);
    vs_d       = fv1_q & (state_d != SYNC);
    line_start = de_d & ~de_q;
    line_end   = de_q & ~de_d;
    data_d     = de_d ? data1_q : data_q;

    if (line_start)                      pix_cnt_d = 12'd1;
    else if (de_d && pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 12'd1;
    else                                 pix_cnt_d = pix_cnt_q;

    if (fv_rise)                                line_cnt_d = 12'd0;
    else if (line_end && line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 12'd1;
    else                                        line_cnt_d = line_cnt_q;

    if (fv_rise)       last_len_d = 12'd0;
    else if (line_end) last_len_d = pix_cnt_q;
    else               last_len_d = last_len_q;

    // de_end_q marks the cycle after oDE fell; reloading restarts the pulse.
    if (de_end_q)                 hs_cnt_d = HS_LOAD;
    else if (hs_cnt_q != '0)      hs_cnt_d = hs_cnt_q - HCW'(1);
    else                          hs_cnt_d = hs_cnt_q;
    hs_d = (hs_cnt_d != '0);

    pix_out_d  = pix_out_q;
    line_out_d = line_out_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    mv_d       = 1'b0;
    if (state_q == DONE) begin
      pix_out_d  = last_len_q;
      line_out_d = line_cnt_q;
      err_d      = frame_err;
      mv_d       = 1'b1;
      cnt_d      = cnt_q + 8'd1;
    end else begin
      mv_d       = 1'b0;
    end
  end

`ifdef AR0134_RX_CHECK_EN
  logic        first_seen_q, first_seen_d, mm_q, mm_d;
  logic [11:0] first_len_q, first_len_d;

  // Mismatch tracking: compare every later line of a frame with the first.
  always_comb begin
    first_seen_d = first_seen_q;
    first_len_d  = first_len_q;
    mm_d         = mm_q;
    if (fv_rise) begin
      first_seen_d = 1'b0;
      first_len_d  = 12'd0;
      mm_d         = 1'b0;
    end else begin
      if (line_end && !first_seen_q) begin
        first_seen_d = 1'b1;
        first_len_d  = pix_cnt_q;
      end else if (line_end && pix_cnt_q != first_len_q) begin
        mm_d = 1'b1;
      end else begin
        mm_d = mm_q;
      end
      // FV dropping while the line is still enabled truncates that line.
      if (state_q == ACTIVE && fv_fall && de_q) mm_d = 1'b1;
      else                                      first_seen_d = first_seen_d;
    end
  end

  // Mismatch tracking registers.
  always_ff @(posedge iPixelClk or negedge iRstn) begin
    if (!iRstn) begin
      first_seen_q <= 1'b0;
      first_len_q  <= 12'd0;
      mm_q         <= 1'b0;
    end else begin
      first_seen_q <= first_seen_d;
      first_len_q  <= first_len_d;
      mm_q         <= mm_d;
    end
  end

  assign frame_err = mm_q | (last_len_q != 12'(EXP_PIX)) | (line_cnt_q != 12'(EXP_LINE));
`else
  assign frame_err = 1'b0;
`endif

  // Pipeline, state and output registers.
  always_ff @(posedge iPixelClk or negedge iRstn) begin
    if (!iRstn) begin
      fv1_q      <= 1'b0;
      lv1_q      <= 1'b0;
      data1_q    <= 10'd0;
      fv2_q      <= 1'b0;
      pipe_vld_q <= 1'b0;
      state_q    <= SYNC;
      de_q       <= 1'b0;
      data_q     <= 10'd0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      hs_cnt_q   <= '0;
      de_end_q   <= 1'b0;
      pix_cnt_q  <= 12'd0;
      line_cnt_q <= 12'd0;
      last_len_q <= 12'd0;
      pix_out_q  <= 12'd0;
      line_out_q <= 12'd0;
      mv_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      fv1_q      <= iFV;
      lv1_q      <= iLV;
      data1_q    <= iData;
      fv2_q      <= fv1_q;
      pipe_vld_q <= 1'b1;
      state_q    <= state_d;
      de_q       <= de_d;
      data_q     <= data_d;
      vs_q       <= vs_d;
      hs_q       <= hs_d;
      hs_cnt_q   <= hs_cnt_d;
      de_end_q   <= line_end;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      last_len_q <= last_len_d;
      pix_out_q  <= pix_out_d;
      line_out_q <= line_out_d;
      mv_q       <= mv_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oDE           = de_q;
  assign oHS           = hs_q;
  assign oVS           = vs_q;
  assign oData         = data_q;
  assign oPixPerLine   = pix_out_q;
  assign oLinePerFrame = line_out_q;
  assign oMeasValid    = mv_q;
  assign oFrameErr     = err_q;
  assign oFrameCnt     = cnt_q;

endmodule
